frac_block_feeder: RTL and testbench

//  Transmit side of the QPEL fractional-search line interface. Holds one 8x8 current block and one
//  8x8 original block (8 lines x 64b each), streams them to the search engine, then captures its
//  SAD/MV result. It sits between the block fetch logic and the search engine.

---
 rtl/frac_block_feeder.sv | 225 ++++++++++++++++++++++
 tb/tb_frac_block_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_block_feeder.sv
// frac_block_feeder: transmit side of the QPEL fractional-search line interface.
// It stores one 8x8 current block and one 8x8 original block, streams them to the
// search engine line by line, and captures the SAD/MV result that comes back.
// Optional feature: define FRAC_FEED_DBUF_EN for double-buffered storage. Loads then
// target the idle bank in any state. Without it there is a single bank, and a load is
// accepted only in IDLE when start is low.
module frac_block_feeder #(
    parameter int RESULT_LAT = 2,   // cycles after the last line at which results are sampled (1..15)
    parameter int SAD_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic             ld_sel,
    input  logic [2:0]       ld_addr,
    input  logic [63:0]      ld_data,
    output logic             ld_err,
    input  logic             start,
    output logic             busy,
    output logic             ready,
    output logic [63:0]      cur_pix,
    output logic [47:0]      org_pix,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [2:0]       mvx_in,
    input  logic [2:0]       mvy_in,
    output logic             res_valid,
    output logic [SAD_W-1:0] res_sad,
    output logic [2:0]       res_mvx,
    output logic [2:0]       res_mvy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The last WAIT cycle, counted from 0. Its closing edge captures the engine result.
    localparam logic [3:0] WAIT_LAST = 4'(RESULT_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] line_cnt_q, line_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       ld_err_q, ld_err_d;
    logic       start_accept;
    logic       capture_en;
    logic       wr_en;

    logic [SAD_W-1:0] res_sad_q;
    logic [2:0]       res_mvx_q, res_mvy_q;

    assign start_accept = (state_q == S_IDLE) && start;
    assign capture_en   = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);

    // ---------------------------------------------------------------------
    // Storage banking: the address carries a bank bit only with double buffering
    // ---------------------------------------------------------------------
`ifdef FRAC_FEED_DBUF_EN
    localparam int AW = 4;

    logic send_bank_q, send_bank_d;
    logic [AW-1:0] wr_addr, cur_rd_addr, org_rd_addr;

    // The bank being sent flips at the edge that accepts a start.
    always_comb begin
        send_bank_d = start_accept ? ~send_bank_q : send_bank_q;
    end

    // Bank pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_bank_q <= 1'b0;
        end else begin
            send_bank_q <= send_bank_d;
        end
    end

    // A load always writes the bank that is idle after this edge. In the start cycle
    // that is the bank that was being sent until now.
    assign wr_en       = ld_valid;
    assign wr_addr     = {~send_bank_d, ld_addr};
    assign cur_rd_addr = {send_bank_q, line_cnt_q};
    assign org_rd_addr = {send_bank_q, line_cnt_q - 3'd1};
    assign ld_err_d    = 1'b0;
`else
    localparam int AW = 3;

    logic [AW-1:0] wr_addr, cur_rd_addr, org_rd_addr;

    // A single bank can be written only while nothing is streaming or about to stream.
    assign wr_en       = ld_valid && (state_q == S_IDLE) && !start;
    assign wr_addr     = ld_addr;
    assign cur_rd_addr = line_cnt_q;
    assign org_rd_addr = line_cnt_q - 3'd1;
    assign ld_err_d    = ld_valid && !wr_en;
`endif

    localparam int DEPTH = 1 << AW;

    logic [63:0] cur_mem [DEPTH];
    logic [47:0] org_mem [DEPTH];   // only bits [55:8] of an original line are ever sent

    // Line storage write port.
    // NOTE: the storage arrays have no reset. Their contents are undefined until loaded, and
    // leaving them unreset lets them map onto plain RAM or register-file cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (ld_sel) begin
                org_mem[wr_addr] <= ld_data[55:8];
            end else begin
                cur_mem[wr_addr] <= ld_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------

    // State, counters and the load-error flag.
    // NOTE: sequential state uses non-blocking assignments, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            line_cnt_q <= 3'd0;
            wait_cnt_q <= 4'd0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ld_err_q   <= ld_err_d;
        end
    end

    // Next state and counter updates.
    // NOTE: every variable is assigned a default at the top of the block, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        line_cnt_d = 3'd0;
        wait_cnt_d = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // The counter wraps 7 -> 0 on exit, so it reads 0 at the next SEND entry.
                line_cnt_d = line_cnt_q + 3'd1;
                if (line_cnt_q == 3'd7) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Streaming outputs decode the registered state, so they drop as soon as reset is asserted.
    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        cur_pix   = 64'd0;
        org_pix   = 48'd0;
        case (state_q)
            S_SEND: begin
                ready   = 1'b1;
                busy    = 1'b1;
                cur_pix = cur_mem[cur_rd_addr];
                // Original lines trail by one and start at line 1. Lines 0 and 7 are never sent.
                if (line_cnt_q >= 3'd2) begin
                    org_pix = org_mem[org_rd_addr];
                end
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Result capture
    // ---------------------------------------------------------------------

    // Register the engine result at the close of the last WAIT cycle and hold it until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_sad_q <= '0;
            res_mvx_q <= 3'd0;
            res_mvy_q <= 3'd0;
        end else if (capture_en) begin
            res_sad_q <= sad_in;
            res_mvx_q <= mvx_in;
            res_mvy_q <= mvy_in;
        end
    end

    assign res_sad = res_sad_q;
    assign res_mvx = res_mvx_q;
    assign res_mvy = res_mvy_q;
    assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_frac_block_feeder.sv
// tb_frac_block_feeder: directed, table-driven bench for frac_block_feeder.
// One table holds the expected per-cycle view of a block (cycles 0..11 after the accepting edge).
// Multi-cycle corner cases are hand-written sequences: a held start, illegal loads,
// a reset in mid-stream and, in the double-buffered build, a bank swap.
module tb_frac_block_feeder;

    localparam int SAD_W = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             ld_valid;
    logic             ld_sel;
    logic [2:0]       ld_addr;
    logic [63:0]      ld_data;
    logic             ld_err;
    logic             start;
    logic             busy;
    logic             ready;
    logic [63:0]      cur_pix;
    logic [47:0]      org_pix;
    logic [SAD_W-1:0] sad_in;
    logic [2:0]       mvx_in;
    logic [2:0]       mvy_in;
    logic             res_valid;
    logic [SAD_W-1:0] res_sad;
    logic [2:0]       res_mvx;
    logic [2:0]       res_mvy;

    int checks   = 0;
    int failures = 0;

    frac_block_feeder #(.RESULT_LAT(2), .SAD_W(SAD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .start     (start),
        .busy      (busy),
        .ready     (ready),
        .cur_pix   (cur_pix),
        .org_pix   (org_pix),
        .sad_in    (sad_in),
        .mvx_in    (mvx_in),
        .mvy_in    (mvy_in),
        .res_valid (res_valid),
        .res_sad   (res_sad),
        .res_mvx   (res_mvx),
        .res_mvy   (res_mvy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SAD_W-1:0] sad;
        logic [2:0]       mvx;
        logic [2:0]       mvy;
        logic             exp_ready;
        logic             exp_busy;
        logic             exp_rv;
        logic [63:0]      exp_cur;
        logic [47:0]      exp_org;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern p of current line k.
    function automatic logic [63:0] cur64(input int p, input int k);
        logic [63:0] v;
        v = 64'h0101_0101_0101_0101 * 64'(k);
        return (p != 0) ? ~v : v;
    endfunction

    // Pattern p of original line j. Every byte carries j, so bits [55:8] identify the line.
    function automatic logic [7:0] org_byte(input int p, input int j);
        return ((p != 0) ? 8'h0F : 8'hF0) ^ 8'(j);
    endfunction

    function automatic logic [63:0] org64(input int p, input int j);
        return {8{org_byte(p, j)}};
    endfunction

    function automatic logic [47:0] org48(input int p, input int j);
        return {6{org_byte(p, j)}};
    endfunction

    // Expected view of one block for pattern p: start accepted at edge E0, cycle c follows E0+c.
    task automatic fill_table(input int p);
        for (int c = 0; c < 12; c++) begin
            vecs[c].sad       = (c == 9) ? 12'h123 : 12'h000;
            vecs[c].mvx       = (c == 9) ? 3'd3 : 3'd0;
            vecs[c].mvy       = (c == 9) ? 3'd5 : 3'd0;
            vecs[c].exp_ready = (c < 8);
            vecs[c].exp_busy  = (c < 11);
            vecs[c].exp_rv    = (c == 10);
            vecs[c].exp_cur   = (c < 8) ? cur64(p, c) : 64'd0;
            vecs[c].exp_org   = (c >= 2 && c < 8) ? org48(p, c - 1) : 48'd0;
        end
    endtask

    task automatic load_line(input logic sel, input int addr, input logic [63:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 3'(addr);
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    // Runs one block from IDLE and compares against the table.
    // inj: -2 = no illegal load, -1 = load together with start, c = load in cycle c.
    task automatic run_block(input int inj, input string tag);
        start    = 1'b1;
        ld_valid = (inj == -1);
        ld_sel   = 1'b0;
        ld_addr  = 3'd5;
        ld_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ld_valid = (c == inj);
            ld_sel   = 1'b0;
            ld_addr  = 3'(c);
            ld_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            sad_in   = vecs[c].sad;
            mvx_in   = vecs[c].mvx;
            mvy_in   = vecs[c].mvy;
            #1;
            check($sformatf("%s_c%0d_ready", tag, c), 64'(ready), 64'(vecs[c].exp_ready));
            check($sformatf("%s_c%0d_busy", tag, c), 64'(busy), 64'(vecs[c].exp_busy));
            check($sformatf("%s_c%0d_res_valid", tag, c), 64'(res_valid), 64'(vecs[c].exp_rv));
            check($sformatf("%s_c%0d_cur_pix", tag, c), cur_pix, vecs[c].exp_cur);
            check($sformatf("%s_c%0d_org_pix", tag, c), 64'(org_pix), 64'(vecs[c].exp_org));
            check($sformatf("%s_c%0d_ld_err", tag, c), 64'(ld_err), 64'(c == inj + 1));
            if (c == 10) begin
                check($sformatf("%s_res_sad", tag), 64'(res_sad), 64'(12'h123));
                check($sformatf("%s_res_mvx", tag), 64'(res_mvx), 64'(3'd3));
                check($sformatf("%s_res_mvy", tag), 64'(res_mvy), 64'(3'd5));
            end
            tick();
        end
        ld_valid = 1'b0;
        sad_in   = '0;
        mvx_in   = 3'd0;
        mvy_in   = 3'd0;
        #1;
        check($sformatf("%s_res_hold", tag), 64'({res_sad, res_mvx, res_mvy}), 64'({12'h123, 3'd3, 3'd5}));
    endtask

    logic [29:0] ready_trace, busy_trace, ready_exp, busy_exp;
    logic        rv_seen;
    logic        drained;

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_addr  = 3'd0;
        ld_data  = 64'd0;
        start    = 1'b0;
        sad_in   = '0;
        mvx_in   = 3'd0;
        mvy_in   = 3'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ld_err", 64'(ld_err), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_cur_pix", cur_pix, 64'd0);
        check("rst_org_pix", 64'(org_pix), 64'd0);
        check("rst_res", 64'({res_sad, res_mvx, res_mvy}), 64'd0);
        reset = 1'b0;
        tick();

        // Load pattern 0 and stream it.
        for (int k = 0; k < 8; k++) load_line(1'b0, k, cur64(0, k));
        for (int j = 0; j < 8; j++) load_line(1'b1, j, org64(0, j));
        #1;
        check("legal_load_ld_err", 64'(ld_err), 64'd0);
        fill_table(0);
        run_block(-2, "blk0");

`ifndef FRAC_FEED_DBUF_EN
        // Illegal loads in SEND, at start and in WAIT: one ld_err pulse each, contents unchanged.
        run_block(3, "ld_send");
        run_block(-2, "after_ld_send");
        run_block(-1, "ld_start");
        run_block(9, "ld_wait");
        run_block(-2, "after_ld_wait");
`endif

        // Start held high: 8 ready cycles, then 4 low cycles (WAIT x2, DONE, IDLE), repeating.
        start = 1'b1;
        tick();
        for (int c = 0; c < 30; c++) begin
            ready_trace[c] = ready;
            busy_trace[c]  = busy;
            ready_exp[c]   = ((c % 12) < 8);
            busy_exp[c]    = ((c % 12) < 11);
            tick();
        end
        start = 1'b0;
        check("held_start_ready_pattern", 64'(ready_trace), 64'(ready_exp));
        check("held_start_busy_pattern", 64'(busy_trace), 64'(busy_exp));
        drained = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) begin
                drained = 1'b1;
                break;
            end
            tick();
        end
        check("held_start_drain", 64'(drained), 64'd1);
        tick();

        // Reset in SEND cycle 4: ready drops at once, and no result is issued.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_abort_ready", 64'(ready), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cur_pix", cur_pix, 64'd0);
        tick();
        tick();
        reset   = 1'b0;
        rv_seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (res_valid || busy) rv_seen = 1'b1;
            tick();
        end
        check("abort_no_res_valid", 64'(rv_seen), 64'd0);
        run_block(-2, "post_reset");

`ifdef FRAC_FEED_DBUF_EN
        // Load bank B with pattern 1 during a bank-A send, then start: the burst carries pattern 1.
        rv_seen = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ld_valid = 1'b1;
            ld_sel   = (c >= 8);
            ld_addr  = 3'(c % 8);
            ld_data  = (c < 8) ? cur64(1, c) : org64(1, c - 8);
            #1;
            if (ld_err) rv_seen = 1'b1;
            tick();
        end
        ld_valid = 1'b0;
        #1;
        if (ld_err) rv_seen = 1'b1;
        check("dbuf_ld_err_never", 64'(rv_seen), 64'd0);
        fill_table(1);
        run_block(-2, "bank_b");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog: the directed run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
